regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with registered reads, per-write-port enables,

---
 rtl/regfile_mp_sb.sv | 106 ++++++++++
 tb/tb_regfile_mp_sb.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with registered reads, optional write-to-read
// bypass, hardwired zero register and a per-register busy scoreboard.
module regfile_mp_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = $clog2(NREGS),
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*AW-1:0]     wr_addr,
   input  logic [NWR*XLEN-1:0]   wr_data,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_addr,
   output logic [NREGS*XLEN-1:0] dbg_regs
);

   localparam bit ZR = ZERO_REG[0];
   localparam bit BP = BYPASS[0];

   logic [NREGS-1:0][XLEN-1:0] regs_r;
   logic [NREGS-1:0][XLEN-1:0] regs_next_s;
   logic [NREGS-1:0]           busy_r;
   logic [NREGS-1:0]           busy_next_s;
   logic [NRD-1:0][XLEN-1:0]   rd_data_r;
   logic [NRD-1:0]             rd_busy_r;
   logic [NRD-1:0][XLEN-1:0]   rd_val_s;
   logic [NRD-1:0]             rd_bsy_s;
   logic [NWR-1:0]             wr_ok_s;
   logic                       iss_ok_s;

   // Out-of-range addresses and the hardwired zero register are never written, read or marked.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      addr_ok = (32'(a) < NREGS) && !(ZR && (a == '0));
   endfunction

   // Accept/qualify each write port and the issue request.
   always_comb begin
      wr_ok_s = '0;
      for (int j = 0; j < NWR; j++) begin
         wr_ok_s[j] = wr_en[j] && addr_ok(wr_addr[j*AW +: AW]);
      end
      iss_ok_s = iss_en && addr_ok(iss_addr);
   end

   // Next register/busy state; later ports overwrite earlier ones, issue overrides writeback clear.
   always_comb begin
      regs_next_s = regs_r;
      busy_next_s = busy_r;
      for (int r = 0; r < NREGS; r++) begin
         for (int j = 0; j < NWR; j++) begin
            regs_next_s[r] = (wr_ok_s[j] && (32'(wr_addr[j*AW +: AW]) == r))
                             ? wr_data[j*XLEN +: XLEN] : regs_next_s[r];
            busy_next_s[r] = (wr_ok_s[j] && (32'(wr_addr[j*AW +: AW]) == r))
                             ? 1'b0 : busy_next_s[r];
         end
         busy_next_s[r] = (iss_ok_s && (32'(iss_addr) == r)) ? 1'b1 : busy_next_s[r];
      end
   end

   // Read mux: bypass selects post-write data; busy always reflects the post-edge scoreboard.
   always_comb begin
      rd_val_s = '0;
      rd_bsy_s = '0;
      for (int i = 0; i < NRD; i++) begin
         for (int r = 0; r < NREGS; r++) begin
            rd_val_s[i] = (addr_ok(rd_addr[i*AW +: AW]) && (32'(rd_addr[i*AW +: AW]) == r))
                          ? (BP ? regs_next_s[r] : regs_r[r]) : rd_val_s[i];
            rd_bsy_s[i] = (addr_ok(rd_addr[i*AW +: AW]) && (32'(rd_addr[i*AW +: AW]) == r))
                          ? busy_next_s[r] : rd_bsy_s[i];
         end
      end
   end

   // State and registered read outputs; disabled read ports hold their last result.
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_r    <= '0;
         busy_r    <= '0;
         rd_data_r <= '0;
         rd_busy_r <= '0;
      end else begin
         regs_r <= regs_next_s;
         busy_r <= busy_next_s;
         for (int i = 0; i < NRD; i++) begin
            if (rd_en[i]) begin
               rd_data_r[i] <= rd_val_s[i];
               rd_busy_r[i] <= rd_bsy_s[i];
            end
         end
      end
   end

   assign rd_data  = rd_data_r;
   assign rd_busy  = rd_busy_r;
   assign dbg_regs = regs_r;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed table-driven bench for regfile_mp_sb (NWR=2); a BYPASS=0 twin shares the inputs.
module tb_regfile_mp_sb;
   localparam int XLEN = 32, NREGS = 32, AW = 5, NRD = 2, NWR = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NRD-1:0]        rd_en = '0;
   logic [NRD*AW-1:0]     rd_addr = '0;
   logic [NWR-1:0]        wr_en = '0;
   logic [NWR*AW-1:0]     wr_addr = '0;
   logic [NWR*XLEN-1:0]   wr_data = '0;
   logic                  iss_en = 1'b0;
   logic [AW-1:0]         iss_addr = '0;
   logic [NRD*XLEN-1:0]   rd_data, rd_data_nb;
   logic [NRD-1:0]        rd_busy, rd_busy_nb;
   logic [NREGS*XLEN-1:0] dbg_regs, dbg_regs_nb;

   int pass_cnt = 0;
   int total_cnt = 0;

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .dbg_regs(dbg_regs));

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
      .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .dbg_regs(dbg_regs_nb));

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  re;
      logic [4:0]  ra0, ra1;
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        ie;
      logic [4:0]  ia;
      logic [31:0] ed0, ed1;   // expected rd_data ports 0/1 (bypass instance)
      logic [1:0]  eb;         // expected rd_busy (bypass instance)
      logic [31:0] en0;        // expected rd_data port 0 of the no-bypass instance
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input vec_t v);
      reset    = v.rst;
      rd_en    = v.re;
      rd_addr  = {v.ra1, v.ra0};
      wr_en    = v.we;
      wr_addr  = {v.wa1, v.wa0};
      wr_data  = {v.wd1, v.wd0};
      iss_en   = v.ie;
      iss_addr = v.ia;
   endtask

   task automatic idle();
      reset = 1'b0; rd_en = '0; rd_addr = '0; wr_en = '0;
      wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          rst re  ra0 ra1 we  wa0 wd0           wa1 wd1           ie ia  ed0           ed1           eb     en0
      vecs[0]  = '{1'b0, 2'b00, 5'd0,  5'd0, 2'b01, 5'd3,  32'h12345678, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
      vecs[1]  = '{1'b0, 2'b11, 5'd3,  5'd3, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h12345678, 32'h12345678, 2'b00, 32'h12345678};
      vecs[2]  = '{1'b0, 2'b11, 5'd7,  5'd3, 2'b10, 5'd0,  32'h0,        5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  32'hA5A5A5A5, 32'h12345678, 2'b00, 32'h0};
      vecs[3]  = '{1'b0, 2'b11, 5'd0,  5'd7, 2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,        32'hA5A5A5A5, 2'b00, 32'h0};
      vecs[4]  = '{1'b0, 2'b00, 5'd0,  5'd0, 2'b11, 5'd9,  32'h1,        5'd9,  32'h2,        1'b0, 5'd0,  32'h0,        32'hA5A5A5A5, 2'b00, 32'h0};
      vecs[5]  = '{1'b0, 2'b11, 5'd9,  5'd3, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h2,        32'h12345678, 2'b00, 32'h2};
      vecs[6]  = '{1'b0, 2'b11, 5'd4,  5'd3, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd4,  32'h0,        32'h12345678, 2'b01, 32'h0};
      vecs[7]  = '{1'b0, 2'b10, 5'd0,  5'd4, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        2'b11, 32'h0};
      vecs[8]  = '{1'b0, 2'b01, 5'd4,  5'd0, 2'b01, 5'd4,  32'h55,       5'd0,  32'h0,        1'b1, 5'd4,  32'h55,       32'h0,        2'b11, 32'h0};
      vecs[9]  = '{1'b0, 2'b01, 5'd4,  5'd0, 2'b01, 5'd4,  32'h66,       5'd0,  32'h0,        1'b0, 5'd0,  32'h66,       32'h0,        2'b10, 32'h55};
      vecs[10] = '{1'b0, 2'b00, 5'd0,  5'd0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h66,       32'h0,        2'b10, 32'h55};
      vecs[11] = '{1'b0, 2'b11, 5'd4,  5'd4, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h66,       32'h66,       2'b00, 32'h66};
      vecs[12] = '{1'b0, 2'b11, 5'd12, 5'd9, 2'b11, 5'd12, 32'h111,      5'd12, 32'h222,      1'b1, 5'd20, 32'h222,      32'h2,        2'b00, 32'h0};
      vecs[13] = '{1'b1, 2'b11, 5'd5,  5'd5, 2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        1'b1, 5'd3,  32'h0,        32'h0,        2'b00, 32'h0};
      vecs[14] = '{1'b0, 2'b11, 5'd5,  5'd20, 2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
      vecs[15] = '{1'b0, 2'b11, 5'd12, 5'd9, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        2'b00, 32'h0};

      idle();
      reset = 1'b1;
      tick();
      tick();
      chk("reset_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
      chk("reset_rd_busy", {30'h0, rd_busy}, 32'h0);
      chk("reset_dbg_or", (|dbg_regs) ? 32'h1 : 32'h0, 32'h0);
      reset = 1'b0;

      for (int k = 0; k < NV; k++) begin
         drive(vecs[k]);
         tick();
         chk($sformatf("v%0d_d0", k), rd_data[31:0], vecs[k].ed0);
         chk($sformatf("v%0d_d1", k), rd_data[63:32], vecs[k].ed1);
         chk($sformatf("v%0d_busy", k), {30'h0, rd_busy}, {30'h0, vecs[k].eb});
         chk($sformatf("v%0d_nb_d0", k), rd_data_nb[31:0], vecs[k].en0);
      end
      idle();

      // Reset in the middle of traffic discards the concurrent write.
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
      rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
      tick();
      chk("pre_rst_rd_x5", rd_data[31:0], 32'hDEADBEEF);
      chk("pre_rst_dbg_x5", dbg_regs[5*XLEN +: XLEN], 32'hDEADBEEF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wr_en = '0; rd_en = '0;
      chk("rst_rd_d0", rd_data[31:0], 32'h0);
      chk("rst_rd_d1", rd_data[63:32], 32'h0);
      chk("rst_dbg_x5", dbg_regs[5*XLEN +: XLEN], 32'h0);
      tick();
      chk("rst_hold_dbg_x5", dbg_regs[5*XLEN +: XLEN], 32'h0);

      // Zero register ignores writes on either port.
      wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFFFFFF, 32'h0};
      tick();
      chk("dbg_x0", dbg_regs[0 +: XLEN], 32'h0);
      chk("nb_dbg_x0", dbg_regs_nb[0 +: XLEN], 32'h0);

      // Busy persists across idle cycles until writeback.
      idle();
      iss_en = 1'b1; iss_addr = 5'd8;
      tick();
      iss_en = 1'b0;
      tick(); tick(); tick();
      rd_en = 2'b01; rd_addr = {5'd0, 5'd8};
      tick();
      chk("busy_x8_held", {31'h0, rd_busy[0]}, 32'h1);
      wr_en = 2'b10; wr_addr = {5'd8, 5'd0}; wr_data = {32'h77, 32'h0};
      tick();
      chk("wb_x8_busy", {31'h0, rd_busy[0]}, 32'h0);
      chk("wb_x8_data", rd_data[31:0], 32'h77);
      chk("wb_x8_nb_data", rd_data_nb[31:0], 32'h0);
      chk("wb_x8_dbg", dbg_regs[8*XLEN +: XLEN], 32'h77);
      idle();
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
